// File: rtl/piso_stream.sv
// Parallel-in serial-out shifter with valid/ready load, per-word bit order, stall and framing.
// Define PISO_STREAM_PARITY_EN to append an even-parity bit after each word.
module piso_stream #(
    parameter int WIDTH = 8,
`ifdef PISO_STREAM_PARITY_EN
    parameter int CNT_W = $clog2(WIDTH + 1)
`else
    parameter int CNT_W = $clog2(WIDTH)
`endif
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [WIDTH-1:0] din,
    input  logic             msb_first,
    input  logic             shift_en,
    output logic             dout,
    output logic             dout_valid,
    output logic             last,
    output logic             busy
);

    typedef enum logic {IDLE, SHIFT} state_t;

`ifdef PISO_STREAM_PARITY_EN
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH);
`else
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);
`endif

    state_t           r_state;
    logic [WIDTH-1:0] r_sreg;
    logic [CNT_W-1:0] r_cnt;
    logic             r_msb;
`ifdef PISO_STREAM_PARITY_EN
    logic             r_par;
`endif

    logic w_shift;
    logic w_last;
    logic w_data;
    logic w_bit;
    logic w_accept;

    assign w_shift  = (r_state == SHIFT);
    assign w_last   = w_shift && (r_cnt == LAST_CNT);
    assign w_data   = r_msb ? r_sreg[WIDTH-1] : r_sreg[0];
`ifdef PISO_STREAM_PARITY_EN
    assign w_bit    = (r_cnt == LAST_CNT) ? r_par : w_data;
`else
    assign w_bit    = w_data;
`endif
    // Reload on the last bit only when the link actually advances, so a stall never drops a word.
    assign load_ready = ~rst & ((r_state == IDLE) | (w_last & shift_en));
    assign w_accept   = load_valid & load_ready;

    assign dout       = w_shift & w_bit;
    assign dout_valid = w_shift;
    assign busy       = w_shift;
    assign last       = w_last;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_sreg  <= '0;
            r_cnt   <= '0;
            r_msb   <= 1'b1;
`ifdef PISO_STREAM_PARITY_EN
            r_par   <= 1'b0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_state <= SHIFT;
                        r_sreg  <= din;
                        r_cnt   <= '0;
                        r_msb   <= msb_first;
`ifdef PISO_STREAM_PARITY_EN
                        r_par   <= ^din;
`endif
                    end
                end
                SHIFT: begin
                    if (shift_en) begin
                        if (r_cnt == LAST_CNT) begin
                            if (w_accept) begin
                                r_sreg <= din;
                                r_cnt  <= '0;
                                r_msb  <= msb_first;
`ifdef PISO_STREAM_PARITY_EN
                                r_par  <= ^din;
`endif
                            end else begin
                                r_state <= IDLE;
                            end
                        end else begin
                            r_sreg <= r_msb ? {r_sreg[WIDTH-2:0], 1'b0}
                                            : {1'b0, r_sreg[WIDTH-1:1]};
                            r_cnt  <= r_cnt + CNT_W'(1);
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_piso_stream.sv
// Bench for piso_stream (WIDTH=4): bit-queue reference model checked every cycle plus directed literals.
module tb_piso_stream;

    localparam int W = 4;
`ifdef PISO_STREAM_PARITY_EN
    localparam int NB = W + 1;
    localparam bit PAR = 1'b1;
`else
    localparam int NB = W;
    localparam bit PAR = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         load_valid = 1'b0;
    logic         load_ready;
    logic [W-1:0] din = '0;
    logic         msb_first = 1'b1;
    logic         shift_en = 1'b1;
    logic         dout;
    logic         dout_valid;
    logic         last;
    logic         busy;

    piso_stream #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .din        (din),
        .msb_first  (msb_first),
        .shift_en   (shift_en),
        .dout       (dout),
        .dout_valid (dout_valid),
        .last       (last),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: the bits still to be sent for the word in flight, front = bit on dout now.
    bit mq[$];
    bit m_acc;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mq.delete();
        end else begin
            m_acc = load_valid && (mq.size() == 0 || (mq.size() == 1 && shift_en));
            if (mq.size() > 0 && shift_en) void'(mq.pop_front());
            if (m_acc) begin
                for (int i = 0; i < W; i++) mq.push_back(msb_first ? din[W-1-i] : din[i]);
                if (PAR) mq.push_back(^din);
            end
        end
    end

    always @(negedge clk) begin
        bit ev;
        bit eb;
        ev = !rst && (mq.size() > 0);
        eb = 1'b0;
        if (ev) eb = mq[0];
        check("m_valid", dout_valid, ev);
        check("m_busy", busy, ev);
        check("m_dout", dout, eb);
        check("m_last", last, ev && (mq.size() == 1));
        check("m_ready", load_ready, !rst && (mq.size() == 0 || (mq.size() == 1 && shift_en)));
    end

    logic [31:0] cap, lcap, rcap;
    int          ncap;
    always @(negedge clk) begin
        if (dout_valid) begin
            cap  = {cap[30:0], dout};
            lcap = {lcap[30:0], last};
            rcap = {rcap[30:0], load_ready};
            ncap++;
        end
    end

    task automatic clr_cap();
        cap = '0; lcap = '0; rcap = '0; ncap = 0;
    endtask

    task automatic one_word(input string nm, input logic [W-1:0] d, input logic m,
                            input logic [W-1:0] exp, input logic p);
        logic [31:0] e;
        e = PAR ? {27'd0, exp, p} : {28'd0, exp};
        clr_cap();
        din = d; msb_first = m; load_valid = 1'b1;
        @(posedge clk); #1;
        load_valid = 1'b0;
        msb_first  = ~m;
        repeat (NB) @(posedge clk);
        #1;
        check({nm, "_bits"}, cap, e);
        check({nm, "_n"}, ncap, NB);
        check({nm, "_last"}, lcap, 32'd1);
        check({nm, "_idle_valid"}, dout_valid, 1'b0);
        check({nm, "_idle_busy"}, busy, 1'b0);
        check({nm, "_idle_ready"}, load_ready, 1'b1);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check("rst_valid", dout_valid, 1'b0);
        check("rst_ready_held", load_ready, 1'b0);
        rst = 1'b0;
        #1;
        check("rst_ready", load_ready, 1'b1);
        check("rst_dout", dout, 1'b0);

        one_word("msb", 4'b1010, 1'b1, 4'b1010, 1'b0);
        one_word("lsb", 4'b1100, 1'b0, 4'b0011, 1'b0);

        // Back-to-back words with load_valid held high
        clr_cap();
        din = 4'b1010; msb_first = 1'b1; load_valid = 1'b1;
        @(posedge clk); #1;
        din = 4'b1100;
        repeat (NB) @(posedge clk);
        #1;
        load_valid = 1'b0;
        repeat (NB) @(posedge clk);
        #1;
`ifdef PISO_STREAM_PARITY_EN
        check("b2b_bits", cap, 32'b1010011000);
        check("b2b_ready", rcap, 32'b0000100001);
`else
        check("b2b_bits", cap, 32'b10101100);
        check("b2b_ready", rcap, 32'b00010001);
`endif
        check("b2b_n", ncap, 2 * NB);

        // Stall for 3 cycles on the second bit
        clr_cap();
        din = 4'b1010; msb_first = 1'b1; load_valid = 1'b1;
        @(posedge clk); #1;
        load_valid = 1'b0;
        @(posedge clk); #1;
        shift_en = 1'b0;
        load_valid = 1'b1; din = 4'b1111;
        @(posedge clk); #1;
        check("stall_ready", load_ready, 1'b0);
        check("stall_dout", dout, 1'b0);
        check("stall_valid", dout_valid, 1'b1);
        repeat (2) @(posedge clk);
        #1;
        load_valid = 1'b0;
        shift_en = 1'b1;
        repeat (NB - 1) @(posedge clk);
        #1;
`ifdef PISO_STREAM_PARITY_EN
        check("stall_bits", cap, 32'b10000100);
`else
        check("stall_bits", cap, 32'b1000010);
`endif
        check("stall_n", ncap, NB + 3);
        check("stall_end_valid", dout_valid, 1'b0);

        // Asynchronous reset mid-word
        din = 4'b0110; msb_first = 1'b1; load_valid = 1'b1;
        @(posedge clk); #1;
        load_valid = 1'b0;
        @(posedge clk); #2;
        check("pre_rst_valid", dout_valid, 1'b1);
        check("pre_rst_dout", dout, 1'b1);
        rst = 1'b1;
        #1;
        check("arst_valid", dout_valid, 1'b0);
        check("arst_busy", busy, 1'b0);
        check("arst_dout", dout, 1'b0);
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        check("post_rst_valid", dout_valid, 1'b0);
        one_word("after_rst", 4'b1001, 1'b1, 4'b1001, 1'b0);

`ifdef PISO_STREAM_PARITY_EN
        one_word("par1", 4'b1011, 1'b1, 4'b1011, 1'b1);
        one_word("par0", 4'b1001, 1'b1, 4'b1001, 1'b0);
`endif

        repeat (2) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1);
    end

endmodule

// File: doc/piso_stream.md
Name: piso_stream

Overview:
- Parametrised parallel-in serial-out shifter with valid/ready load handshake, per-word bit-order select, shift-enable stall and framing outputs.
- Generalises the team's fixed 4-bit PISO to any width.
- Supports gapless back-to-back words.
- Sits between a parallel word source (FIFO or register bank) and a serial link or bit-serial datapath.

Parameters:
- WIDTH, 8, parallel word width in bits; legal range 2..64.
- CNT_W, $clog2(WIDTH), width of the internal bit counter; derived, do not override.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- load_valid  input  1  source has a word on din
- load_ready  output  1  block accepts din this cycle
- din  input  WIDTH  parallel word
- msb_first  input  1  bit order for the word being loaded: 1 = MSB first, 0 = LSB first; sampled only on accept
- shift_en  input  1  advance one bit this cycle; 0 = stall, all state held
- dout  output  1  serial data bit
- dout_valid  output  1  dout carries a word bit
- last  output  1  dout is the final bit of the current word
- busy  output  1  a word is in flight (state SHIFT)

Behaviour:
- Reset (async, immediate on rst=1):
  - state=IDLE, shift register=0, counter=0, order flag=1.
  - Outputs: dout=0, dout_valid=0, last=0, busy=0, load_ready=1 while rst=0 and IDLE.
- Accept = load_valid & load_ready, evaluated at the rising edge.
- States: IDLE, SHIFT.
- IDLE:
  - load_ready=1.
  - On accept: shift register<=din, order flag<=msb_first, counter<=0, go to SHIFT.
  - Without accept: stay in IDLE.
- SHIFT:
  - dout = order flag ? sreg[WIDTH-1] : sreg[0], driven combinationally from registers.
  - dout_valid=1, busy=1.
  - last = (counter==WIDTH-1).
  - load_ready = last & shift_en.
- SHIFT, shift_en=1, counter<WIDTH-1:
  - Shift one position toward the output end (left for MSB first, right for LSB first); zero fill.
  - counter+1.
- SHIFT, shift_en=1, counter==WIDTH-1:
  - With accept: reload exactly as in IDLE and remain in SHIFT. No bubble, so bit 0 of the new word follows the last bit of the old word on the next cycle.
  - Without accept: go to IDLE; dout_valid=0, dout=0.
- SHIFT, shift_en=0: everything held, load_ready=0. din is ignored even if load_valid=1.
- Latency: the first bit appears on dout in the cycle after the accept edge. A word occupies exactly WIDTH cycles in which shift_en=1.
- In IDLE, shift_en is don't-care.
- msb_first changes while in SHIFT have no effect on the word in flight.
- Reset mid-word: the word is discarded, no partial output after release, and the block is ready on the first edge after rst deasserts.
- Counter never exceeds WIDTH-1; no wrap.

Optional Feature:
- Macro: PISO_STREAM_PARITY_EN.
- Defined:
  - An even-parity bit (XOR of all WIDTH bits of the loaded word) is appended after the last data bit.
  - A word then occupies WIDTH+1 enabled cycles. last asserts on the parity bit, and load_ready follows last.
  - The counter is widened to hold WIDTH.
- Undefined: no parity bit; behaviour exactly as above.

Test Plan:
- Reset and single word: rst=1 for 2 cycles, then WIDTH=4, din=4'b1010, msb_first=1, shift_en=1 held, one-cycle load_valid.
  - dout over 4 cycles = 1,0,1,0; last=1 on the 4th bit only.
  - Then dout_valid=0, busy=0, load_ready=1.
- LSB first: din=4'b1100, msb_first=0.
  - dout sequence = 0,0,1,1.
- Back-to-back: load_valid held high with din=4'b1010 then 4'b1100, msb_first=1.
  - 8 consecutive valid bits 1,0,1,0,1,1,0,0 with no dout_valid gap.
  - load_ready high only in the cycle of each last bit.
- Stall: during word 4'b1010, shift_en=0 for 3 cycles after the 2nd bit.
  - dout holds 0, counter holds, load_ready=0.
  - Remaining bits 1,0 follow after shift_en returns.
- Reset mid-word: assert rst asynchronously (between edges) after 2 bits of 4'b0110.
  - dout_valid, busy and dout drop to 0 immediately, without waiting for an edge.
  - After release, a new load of 4'b1001 serialises as 1,0,0,1.
- Parity (macro defined): din=4'b1011.
  - dout = 1,0,1,1,1 (parity 1); last on the 5th bit.
  - din=4'b1001 ends with parity 0.
